// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcodes, FSM state codes and sizing helper
// for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef logic [2:0] mdOp_t;

    localparam mdOp_t OP_MULT  = 3'b000;
    localparam mdOp_t OP_MULTU = 3'b001;
    localparam mdOp_t OP_DIV   = 3'b010;
    localparam mdOp_t OP_DIVU  = 3'b011;
    localparam mdOp_t OP_MFHI  = 3'b100;
    localparam mdOp_t OP_MFLO  = 3'b101;
    localparam mdOp_t OP_MTHI  = 3'b110;
    localparam mdOp_t OP_MTLO  = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/response bundle between the EX-stage
// issue logic (master) and the multiply/divide unit (slave).
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);

    logic             flush;
    logic             AnyStall;
    logic             MdVal_ID;
    logic [2:0]       MdOp_ID;
    logic [WIDTH-1:0] SrcA_ID;
    logic [WIDTH-1:0] SrcB_ID;
    logic             MdStall_EXM1;
    logic             Busy_EX;
    logic [WIDTH-1:0] HiLoRd_EX;
    logic             HiLoRdVal_EX;

    modport master (
        output flush,
        output AnyStall,
        output MdVal_ID,
        output MdOp_ID,
        output SrcA_ID,
        output SrcB_ID,
        input  MdStall_EXM1,
        input  Busy_EX,
        input  HiLoRd_EX,
        input  HiLoRdVal_EX
    );

    modport slave (
        input  flush,
        input  AnyStall,
        input  MdVal_ID,
        input  MdOp_ID,
        input  SrcA_ID,
        input  SrcB_ID,
        output MdStall_EXM1,
        output Busy_EX,
        output HiLoRd_EX,
        output HiLoRdVal_EX
    );

endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-divide step producing
// the next partial remainder and one quotient bit.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic             bitIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic             qBit
);

    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    // With a zero divisor the compare always succeeds and the remainder
    // simply shifts the dividend through, leaving it intact at the end.
    always_comb begin
        part   = {remIn, bitIn};
        diff   = part - {1'b0, divisor};
        qBit   = (part >= {1'b0, divisor});
        remOut = qBit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative HI/LO multiply/divide unit beside the EX ALU.
// Define MULDIV_DIV_EN to build the divider; else DIV/DIVU are no-ops.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int MUL_RADIX_BITS = 1
) (
    input logic        clk,
    input logic        reset,
    ex_muldiv_if.slave md
);

    localparam int R         = MUL_RADIX_BITS;
    localparam int MUL_ITERS = WIDTH / R;
    localparam int CNT_W     = clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   opM;
    logic               negRes;
    logic [WIDTH-1:0]   hiLoRd;
    logic               hiLoRdVal;

    logic [2:0]         op;
    logic               busy;
    logic               accept;
    logic               isSigned;
    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH+R-1:0] mulAdd;
    logic [WIDTH+R-1:0] mulSum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodFix;

    assign op     = md.MdOp_ID;
    assign busy   = (state != S_IDLE);
    assign accept = md.MdVal_ID & ~md.flush & ~md.AnyStall & ~busy;

    assign md.MdStall_EXM1 = md.MdVal_ID & ~md.flush & busy;
    assign md.Busy_EX      = busy;
    assign md.HiLoRd_EX    = hiLoRd;
    assign md.HiLoRdVal_EX = hiLoRdVal;

    assign isSigned = (op == OP_MULT) | (op == OP_DIV);
    assign signA    = isSigned & md.SrcA_ID[WIDTH-1];
    assign signB    = isSigned & md.SrcB_ID[WIDTH-1];
    assign magA     = signA ? -md.SrcA_ID : md.SrcA_ID;
    assign magB     = signB ? -md.SrcB_ID : md.SrcB_ID;

    // Multiplier bits sit in accLo and retire from the bottom, R per cycle.
    always_comb begin
        mulAdd = '0;
        for (int i = 0; i < R; i++) begin
            if (accLo[i]) begin
                mulAdd = mulAdd + ({{R{1'b0}}, opM} << i);
            end
        end
        mulSum = {{R{1'b0}}, accHi} + mulAdd;
    end

    assign prod    = {accHi, accLo};
    assign prodFix = negRes ? -prod : prod;

`ifdef MULDIV_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    logic             isDiv;
    logic             negRem;
    logic             divZero;
    logic [WIDTH-1:0] divRem;
    logic             divQ;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

    muldiv_div_step #(
        .WIDTH(WIDTH)
    ) uDivStep (
        .remIn  (accHi),
        .bitIn  (accLo[WIDTH-1]),
        .divisor(opM),
        .remOut (divRem),
        .qBit   (divQ)
    );

    // Remainder of a zero divide is |SrcA|; the sign fix restores SrcA.
    assign quoFix = divZero ? '1 : (negRes ? -accLo : accLo);
    assign remFix = negRem ? -accHi : accHi;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            accHi     <= '0;
            accLo     <= '0;
            opM       <= '0;
            negRes    <= 1'b0;
            hiLoRd    <= '0;
            hiLoRdVal <= 1'b0;
`ifdef MULDIV_DIV_EN
            isDiv     <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
`endif
        end else begin
            hiLoRdVal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state  <= S_MUL;
                                cnt    <= '0;
                                accHi  <= '0;
                                accLo  <= magB;
                                opM    <= magA;
                                negRes <= signA ^ signB;
`ifdef MULDIV_DIV_EN
                                isDiv  <= 1'b0;
`endif
                            end
`ifdef MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                state   <= S_DIV;
                                cnt     <= '0;
                                accHi   <= '0;
                                accLo   <= magA;
                                opM     <= magB;
                                negRes  <= signA ^ signB;
                                negRem  <= signA;
                                divZero <= (md.SrcB_ID == '0);
                                isDiv   <= 1'b1;
                            end
`endif
                            OP_MFHI: begin
                                hiLoRd    <= hi;
                                hiLoRdVal <= 1'b1;
                            end
                            OP_MFLO: begin
                                hiLoRd    <= lo;
                                hiLoRdVal <= 1'b1;
                            end
                            OP_MTHI: hi <= md.SrcA_ID;
                            OP_MTLO: lo <= md.SrcA_ID;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    accHi <= mulSum[WIDTH+R-1:R];
                    accLo <= {mulSum[R-1:0], accLo[WIDTH-1:R]};
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == MUL_LAST) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    accHi <= divRem;
                    accLo <= {accLo[WIDTH-2:0], divQ};
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (isDiv) begin
                        hi <= remFix;
                        lo <= quoFix;
                    end else begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end
                    state <= S_IDLE;
                end
`else
                S_FIX: begin
                    hi    <= prodFix[2*WIDTH-1:WIDTH];
                    lo    <= prodFix[WIDTH-1:0];
                    state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against
// an arithmetic reference model (radix 1 and radix 4 instances).
module tb_ex_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(W)) mdIf ();
    ex_muldiv_if #(.WIDTH(W)) mdIf4 ();

    ex_muldiv #(.WIDTH(W), .MUL_RADIX_BITS(1)) dut (
        .clk(clk), .reset(reset), .md(mdIf)
    );
    ex_muldiv #(.WIDTH(W), .MUL_RADIX_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .md(mdIf4)
    );

    int compared = 0;
    int mismatched = 0;
    logic [W-1:0] mHi = '0;
    logic [W-1:0] mLo = '0;

    function automatic void refOp(input logic [2:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  inout logic [W-1:0] hi, inout logic [W-1:0] lo);
        longint sp;
        logic [63:0] up;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = sp;
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            OP_DIV: if (DIV_EN) begin
                if (b == '0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == '1) begin lo = a; hi = '0; end
                else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
            end
            OP_DIVU: if (DIV_EN) begin
                if (b == '0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            OP_MTHI: hi = a;
            OP_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    function automatic int expBusy(input logic [2:0] op);
        if (op == OP_MULT || op == OP_MULTU) return W + 1;
        if ((op == OP_DIV || op == OP_DIVU) && DIV_EN) return W + 1;
        return 0;
    endfunction

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic waitIdle();
        int n = 0;
        while (mdIf.Busy_EX === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL waitIdle: busy still %b after %0d cycles", mdIf.Busy_EX, n);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic fl, input logic st);
        waitIdle();
        mdIf.MdVal_ID = 1'b1;
        mdIf.MdOp_ID = op;
        mdIf.SrcA_ID = a;
        mdIf.SrcB_ID = b;
        mdIf.flush = fl;
        mdIf.AnyStall = st;
        @(negedge clk);
        mdIf.MdVal_ID = 1'b0;
        mdIf.flush = 1'b0;
        mdIf.AnyStall = 1'b0;
    endtask

    task automatic measureBusy(output int n);
        n = 0;
        while (mdIf.Busy_EX === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic readReg(input logic [2:0] op, output logic [W-1:0] v, output logic vld);
        issue(op, '0, '0, 1'b0, 1'b0);
        v = mdIf.HiLoRd_EX;
        vld = mdIf.HiLoRdVal_EX;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        logic vld;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        compared++;
        if (mdIf.Busy_EX !== 1'b0) begin
            mismatched++; $display("FAIL reset_busy: got %b want 0", mdIf.Busy_EX);
        end
        compared++;
        if (mdIf.HiLoRdVal_EX !== 1'b0 || mdIf.HiLoRd_EX !== '0) begin
            mismatched++;
            $display("FAIL reset_rd: got val %b data %h want 0/0", mdIf.HiLoRdVal_EX, mdIf.HiLoRd_EX);
        end
        compared++;
        if (mdIf4.Busy_EX !== 1'b0) begin
            mismatched++; $display("FAIL reset_busy4: got %b want 0", mdIf4.Busy_EX);
        end
        readReg(OP_MFHI, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== '0) begin
            mismatched++; $display("FAIL reset_hi: got %b/%h want 1/0", vld, v);
        end
        readReg(OP_MFLO, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== '0) begin
            mismatched++; $display("FAIL reset_lo: got %b/%h want 1/0", vld, v);
        end
    endtask

    task automatic test_mult();
        logic [W-1:0] v;
        logic vld;
        int n;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        measureBusy(n);
        compared++;
        if (n != 33) begin
            mismatched++; $display("FAIL mult_busy: got %0d want 33", n);
        end
        refOp(OP_MULT, 32'hFFFF_FFFD, 32'd7, mHi, mLo);
        readReg(OP_MFHI, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== mHi) begin
            mismatched++; $display("FAIL mult_hi: got %h want %h", v, mHi);
        end
        readReg(OP_MFLO, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== mLo) begin
            mismatched++; $display("FAIL mult_lo: got %h want %h", v, mLo);
        end
    endtask

    task automatic test_div();
        logic [2:0] ops [5] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
        logic [W-1:0] as [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [W-1:0] bs [5] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [W-1:0] v;
        logic vld;
        int n;
        for (int k = 0; k < 5; k++) begin
            issue(OP_MTHI, $urandom, '0, 1'b0, 1'b0);
            refOp(OP_MTHI, mdIf.SrcA_ID, '0, mHi, mLo);
            issue(OP_MTLO, $urandom, '0, 1'b0, 1'b0);
            refOp(OP_MTLO, mdIf.SrcA_ID, '0, mHi, mLo);
            issue(ops[k], as[k], bs[k], 1'b0, 1'b0);
            measureBusy(n);
            compared++;
            if (n != expBusy(ops[k])) begin
                mismatched++; $display("FAIL div%0d_busy: got %0d want %0d", k, n, expBusy(ops[k]));
            end
            refOp(ops[k], as[k], bs[k], mHi, mLo);
            readReg(OP_MFHI, v, vld);
            compared++;
            if (vld !== 1'b1 || v !== mHi) begin
                mismatched++; $display("FAIL div%0d_hi: got %h want %h", k, v, mHi);
            end
            readReg(OP_MFLO, v, vld);
            compared++;
            if (vld !== 1'b1 || v !== mLo) begin
                mismatched++; $display("FAIL div%0d_lo: got %h want %h", k, v, mLo);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] opList [6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
        logic [2:0] op;
        logic [W-1:0] a, b, v;
        logic vld;
        int n;
        for (int k = 0; k < 30; k++) begin
            op = opList[$urandom_range(0, 5)];
            a = randOperand();
            b = randOperand();
            issue(op, a, b, 1'b0, 1'b0);
            measureBusy(n);
            compared++;
            if (n != expBusy(op)) begin
                mismatched++; $display("FAIL rnd%0d_busy op %0d: got %0d want %0d", k, op, n, expBusy(op));
            end
            refOp(op, a, b, mHi, mLo);
            readReg(OP_MFHI, v, vld);
            compared++;
            if (vld !== 1'b1 || v !== mHi) begin
                mismatched++; $display("FAIL rnd%0d_hi op %0d a %h b %h: got %h want %h", k, op, a, b, v, mHi);
            end
            readReg(OP_MFLO, v, vld);
            compared++;
            if (vld !== 1'b1 || v !== mLo) begin
                mismatched++; $display("FAIL rnd%0d_lo op %0d a %h b %h: got %h want %h", k, op, a, b, v, mLo);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b;
        int stalls = 0;
        int n = 0;
        a = $urandom;
        b = $urandom;
        issue(OP_MULT, a, b, 1'b0, 1'b0);
        refOp(OP_MULT, a, b, mHi, mLo);
        repeat (2) @(negedge clk);
        mdIf.MdVal_ID = 1'b1;
        mdIf.MdOp_ID = OP_MFLO;
        #1;
        while (mdIf.Busy_EX === 1'b1 && n < 200) begin
            n++;
            compared++;
            if (mdIf.MdStall_EXM1 !== 1'b1) begin
                mismatched++; $display("FAIL stall_hold%0d: got %b want 1", n, mdIf.MdStall_EXM1);
            end
            stalls++;
            @(negedge clk);
            #1;
        end
        compared++;
        if (mdIf.MdStall_EXM1 !== 1'b0) begin
            mismatched++; $display("FAIL stall_release: got %b want 0", mdIf.MdStall_EXM1);
        end
        @(negedge clk);
        mdIf.MdVal_ID = 1'b0;
        compared++;
        if (stalls != 31) begin
            mismatched++; $display("FAIL stall_count: got %0d want 31", stalls);
        end
        compared++;
        if (mdIf.HiLoRdVal_EX !== 1'b1 || mdIf.HiLoRd_EX !== mLo) begin
            mismatched++;
            $display("FAIL stall_read: got %b/%h want 1/%h", mdIf.HiLoRdVal_EX, mdIf.HiLoRd_EX, mLo);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] v;
        logic vld;
        int n;
        issue(OP_MTLO, 32'h0000_1234, '0, 1'b1, 1'b0);
        readReg(OP_MFLO, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== mLo) begin
            mismatched++; $display("FAIL flush_mtlo: got %h want %h", v, mLo);
        end
        issue(OP_MTHI, 32'h0000_5678, '0, 1'b0, 1'b1);
        readReg(OP_MFHI, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== mHi) begin
            mismatched++; $display("FAIL anystall_mthi: got %h want %h", v, mHi);
        end
        issue(OP_MULTU, 32'd9, 32'd11, 1'b0, 1'b0);
        refOp(OP_MULTU, 32'd9, 32'd11, mHi, mLo);
        mdIf.MdVal_ID = 1'b1;
        mdIf.MdOp_ID = OP_MTHI;
        mdIf.SrcA_ID = 32'hDEAD_BEEF;
        mdIf.flush = 1'b1;
        #1;
        compared++;
        if (mdIf.MdStall_EXM1 !== 1'b0) begin
            mismatched++; $display("FAIL flush_nostall: got %b want 0", mdIf.MdStall_EXM1);
        end
        mdIf.flush = 1'b0;
        #1;
        compared++;
        if (mdIf.MdStall_EXM1 !== 1'b1) begin
            mismatched++; $display("FAIL busy_stall: got %b want 1", mdIf.MdStall_EXM1);
        end
        mdIf.MdVal_ID = 1'b0;
        @(negedge clk);
        measureBusy(n);
        readReg(OP_MFHI, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== mHi) begin
            mismatched++; $display("FAIL flush_inflight_hi: got %h want %h", v, mHi);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, v;
        logic vld;
        int n;
        a = $urandom;
        b = $urandom;
        issue(OP_MULT, a, b, 1'b0, 1'b0);
        refOp(OP_MULT, a, b, mHi, mLo);
        measureBusy(n);
        issue(OP_MULTU, b, a, 1'b0, 1'b0);
        refOp(OP_MULTU, b, a, mHi, mLo);
        compared++;
        if (mdIf.Busy_EX !== 1'b1) begin
            mismatched++; $display("FAIL b2b_accept: got busy %b want 1", mdIf.Busy_EX);
        end
        measureBusy(n);
        compared++;
        if (n != 33) begin
            mismatched++; $display("FAIL b2b_busy: got %0d want 33", n);
        end
        readReg(OP_MFLO, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== mLo) begin
            mismatched++; $display("FAIL b2b_lo: got %h want %h", v, mLo);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        logic vld;
        issue(OP_MULTU, $urandom, $urandom, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mHi = '0;
        mLo = '0;
        compared++;
        if (mdIf.Busy_EX !== 1'b0) begin
            mismatched++; $display("FAIL midreset_busy: got %b want 0", mdIf.Busy_EX);
        end
        readReg(OP_MFHI, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== '0) begin
            mismatched++; $display("FAIL midreset_hi: got %h want 0", v);
        end
        readReg(OP_MFLO, v, vld);
        compared++;
        if (vld !== 1'b1 || v !== '0) begin
            mismatched++; $display("FAIL midreset_lo: got %h want 0", v);
        end
    endtask

    task automatic test_radix4();
        logic [W-1:0] a, b, h, l;
        logic [2:0] op;
        int n;
        h = '0;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 32'hFFFF_FFFF : randOperand();
            b = (k == 0) ? 32'hFFFF_FFFF : randOperand();
            op = (k % 2 == 0) ? OP_MULTU : OP_MULT;
            mdIf4.MdVal_ID = 1'b1;
            mdIf4.MdOp_ID = op;
            mdIf4.SrcA_ID = a;
            mdIf4.SrcB_ID = b;
            @(negedge clk);
            mdIf4.MdVal_ID = 1'b0;
            n = 0;
            while (mdIf4.Busy_EX === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            compared++;
            if (n != 9) begin
                mismatched++; $display("FAIL r4_%0d_busy: got %0d want 9", k, n);
            end
            refOp(op, a, b, h, l);
            mdIf4.MdVal_ID = 1'b1;
            mdIf4.MdOp_ID = OP_MFHI;
            @(negedge clk);
            mdIf4.MdVal_ID = 1'b0;
            compared++;
            if (mdIf4.HiLoRdVal_EX !== 1'b1 || mdIf4.HiLoRd_EX !== h) begin
                mismatched++; $display("FAIL r4_%0d_hi a %h b %h: got %h want %h", k, a, b, mdIf4.HiLoRd_EX, h);
            end
            mdIf4.MdVal_ID = 1'b1;
            mdIf4.MdOp_ID = OP_MFLO;
            @(negedge clk);
            mdIf4.MdVal_ID = 1'b0;
            compared++;
            if (mdIf4.HiLoRdVal_EX !== 1'b1 || mdIf4.HiLoRd_EX !== l) begin
                mismatched++; $display("FAIL r4_%0d_lo a %h b %h: got %h want %h", k, a, b, mdIf4.HiLoRd_EX, l);
            end
        end
    endtask

    initial begin
        mdIf.flush = 1'b0;
        mdIf.AnyStall = 1'b0;
        mdIf.MdVal_ID = 1'b0;
        mdIf.MdOp_ID = '0;
        mdIf.SrcA_ID = '0;
        mdIf.SrcB_ID = '0;
        mdIf4.flush = 1'b0;
        mdIf4.AnyStall = 1'b0;
        mdIf4.MdVal_ID = 1'b0;
        mdIf4.MdOp_ID = '0;
        mdIf4.SrcA_ID = '0;
        mdIf4.SrcB_ID = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_radix4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
